// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - single-port RAM arbiter serving instruction fetches and data accesses
// Data requests win over fetches; each transaction runs REQ -> RESP -> IDLE without preemption.
module mem_responder #(
  parameter logic WAIT_FREEZE = 1'b0
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  input  logic        halt,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ramready,
  output logic [31:0] icount,
  output logic [31:0] dcount
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DREQ   = 3'd1,
    IREQ   = 3'd2,
    DRESP  = 3'd3,
    IRESP  = 3'd4,
    HALTED = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        wr_q, wr_d;
  logic [31:0] imemload_q, imemload_d;
  logic [31:0] dmemload_q, dmemload_d;
  logic [31:0] icount_q, icount_d;
  logic [31:0] dcount_q, dcount_d;
  logic        halt_seen_q;
  logic        cnt_en;

  // Counters advance on the REQ->RESP edge so the count already includes the hit it accompanies.
  assign cnt_en = !(WAIT_FREEZE && halt_seen_q);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      wr_q        <= 1'b0;
      imemload_q  <= '0;
      dmemload_q  <= '0;
      icount_q    <= '0;
      dcount_q    <= '0;
      halt_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      wr_q        <= wr_d;
      imemload_q  <= imemload_d;
      dmemload_q  <= dmemload_d;
      icount_q    <= icount_d;
      dcount_q    <= dcount_d;
      halt_seen_q <= halt_seen_q | halt;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    wr_d       = wr_q;
    imemload_d = imemload_q;
    dmemload_d = dmemload_q;
    icount_d   = icount_q;
    dcount_d   = dcount_q;
    case (state_q)
      IDLE: begin
        if (dmemREN || dmemWEN) begin
          state_d = DREQ;
          addr_d  = dmemaddr;
          data_d  = dmemstore;
          wr_d    = dmemWEN;
        end else if (halt) begin
          state_d = HALTED;
        end else if (imemREN) begin
          state_d = IREQ;
          addr_d  = imemaddr;
          data_d  = '0;
          wr_d    = 1'b0;
        end
      end
      DREQ: begin
        if (ramready) begin
          state_d = DRESP;
          if (!wr_q) dmemload_d = ramload;
          if (cnt_en) dcount_d = dcount_q + 32'd1;
        end
      end
      IREQ: begin
        if (ramready) begin
          state_d    = IRESP;
          imemload_d = ramload;
          if (cnt_en) icount_d = icount_q + 32'd1;
        end
      end
      DRESP:   state_d = IDLE;
      IRESP:   state_d = IDLE;
      HALTED:  state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    if (state_q == DREQ) begin
      ramREN   = !wr_q;
      ramWEN   = wr_q;
      ramaddr  = addr_q;
      ramstore = data_q;
    end else if (state_q == IREQ) begin
      ramREN  = 1'b1;
      ramaddr = addr_q;
    end
  end

  assign ihit     = (state_q == IRESP);
  assign dhit     = (state_q == DRESP);
  assign imemload = imemload_q;
  assign dmemload = dmemload_q;
  assign icount   = icount_q;
  assign dcount   = dcount_q;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named CLK and nRST.
REQ-002 Parameter: WAIT_FREEZE, default 0, meaning that when it is 1 the hit counters do not increment after halt is sampled.
REQ-003 Ports SHALL be as follows, one per line:
  CLK  in  1  clock, rising edge
  nRST  in  1  async active-low reset
  imemREN  in  1  instruction fetch request
  imemaddr  in  32  fetch byte address
  dmemREN  in  1  data read request
  dmemWEN  in  1  data write request
  dmemaddr  in  32  data byte address
  dmemstore  in  32  write data
  halt  in  1  datapath halted
  ihit  out  1  fetch complete, one-cycle pulse
  imemload  out  32  fetched instruction, valid while ihit=1
  dhit  out  1  data access complete, one-cycle pulse
  dmemload  out  32  read data, valid while dhit=1
  ramREN  out  1  RAM read strobe
  ramWEN  out  1  RAM write strobe
  ramaddr  out  32  RAM address
  ramstore  out  32  RAM write data
  ramload  in  32  RAM read data, valid with ramready
  ramready  in  1  RAM access complete this cycle
  icount  out  32  completed fetch count
  dcount  out  32  completed data access count

Function
REQ-004 The FSM SHALL have the states IDLE, DREQ, IREQ, DRESP, IRESP and HALTED.
REQ-005 In IDLE, the next state SHALL be chosen in priority order:
  - (dmemREN|dmemWEN) -> DREQ
  - else halt -> HALTED
  - else imemREN -> IREQ
  - else stay in IDLE
REQ-006 On leaving IDLE for a REQ state, the block SHALL latch the address, the store data, and the kind of access (read or write); later changes on the inputs SHALL NOT affect the transaction in flight.
REQ-007 If dmemREN=dmemWEN=1, the access SHALL be treated as a write.
REQ-008 In DREQ, the RAM outputs SHALL be driven from the latched values: ramaddr=latched address, ramREN=!write, ramWEN=write, ramstore=latched data.
REQ-009 In IREQ, the RAM outputs SHALL be driven as ramREN=1, ramWEN=0, ramaddr=latched fetch address.
REQ-010 In every other state, ramREN, ramWEN, ramaddr and ramstore SHALL all be 0.
REQ-011 A REQ state SHALL hold until ramready=1, then go to the matching RESP state on the next edge, capturing ramload into dmemload (data read) or imemload (fetch).
REQ-012 A data write SHALL leave dmemload unchanged.
REQ-013 dhit SHALL be 1 only in DRESP and ihit SHALL be 1 only in IRESP; each RESP state SHALL last exactly one cycle and then go to IDLE.
REQ-014 Minimum latency SHALL be request sampled in IDLE at cycle 0 -> REQ at cycle 1 with ramready=1 -> hit at cycle 2, giving one extra cycle per ramready wait cycle.
REQ-015 A transaction in flight SHALL NOT be preempted: a data request arriving during IREQ SHALL wait for IRESP -> IDLE and then win arbitration.
REQ-016 A request withdrawn during REQ SHALL still complete, including its RAM access and its hit pulse.
REQ-017 halt asserted during REQ or RESP SHALL let the transaction finish; HALTED SHALL be entered from IDLE with no data request pending.
REQ-018 HALTED SHALL be terminal until nRST, with no RAM strobes and no hits, and imemload and dmemload holding their values.
REQ-019 icount SHALL increment by 1 on every cycle with ihit=1, and dcount on every cycle with dhit=1; both SHALL be modulo 2^32, so 0xFFFFFFFF + 1 = 0.
REQ-020 If WAIT_FREEZE=1, the counters SHALL NOT increment on a hit issued after halt was first sampled high.
REQ-021 imemload and dmemload SHALL be registered; ihit and dhit SHALL be decoded from the state register only, with no combinational path from ramready.

Reset
REQ-022 While nRST=0, state=IDLE and every output SHALL be 0 (ihit, dhit, imemload, dmemload, RAM controls, icount, dcount).
REQ-023 Asserting nRST mid-transaction SHALL drop ramREN/ramWEN asynchronously, the pending hit SHALL be lost, and no hit SHALL follow reset release without a new request.
REQ-024 The first request SHALL be sampled on the first rising edge with nRST=1.

Verification
REQ-025 Fetch: imemREN=1, imemaddr=0x0, ramready=1 in IREQ, ramload=0x3C010001 -> ihit=1 at cycle 2 with imemload=0x3C010001, icount=1.
REQ-026 Contention: imemREN=1 and dmemREN=1 together, dmemaddr=0x80 -> DREQ first, dhit first, then IREQ; the fetch completes with ihit after DRESP -> IDLE.
REQ-027 Wait states: dmemWEN=1, dmemaddr=0x100, dmemstore=0xDEADBEEF, ramready low for 3 cycles -> ramWEN=1, ramaddr=0x100, ramstore=0xDEADBEEF held 4 cycles, dhit at cycle 5, dmemload unchanged.
REQ-028 Halt: halt=1 together with dmemREN=1 in IDLE -> the data access completes with dhit, then HALTED; imemREN=1 afterwards -> no ramREN and no ihit for 20 cycles.
REQ-029 Reset mid-operation: nRST low during DREQ -> ramREN=0 immediately, all outputs 0, and no dhit after release.
REQ-030 Wrap: force icount=0xFFFFFFFF, complete one fetch -> icount=0.
